// File: rtl/uart_pack_tx.sv
// Pack serializer for the UART transmit path: sends out_pattern, freq_pattern and
// ctrl as one PACK_NUM-byte pack over the tx_start/tx_done_tick handshake.
module uart_pack_tx #(
    parameter int DATA_BIT   = 32,
    parameter int PACK_NUM   = (DATA_BIT / 8) * 2 + 1,
    parameter int GAP_CYCLES = 0,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [DATA_BIT-1:0] i_out_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic [7:0]          i_ctrl,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    input  logic                i_tx_done_tick,
    output logic                o_busy,
    output logic                o_done_tick,
    output logic                o_timeout_tick
);

    localparam int SR_W = PACK_NUM * 8;
    localparam int BC_W = $clog2(PACK_NUM);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(PACK_NUM - 1);
    localparam logic [31:0]     GAP_LAST  = 32'(GAP_CYCLES - 1);
    localparam logic [31:0]     TO_LIM    = 32'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT,
        GAP,
        DONE,
        ABORT
    } state_t;

    state_t          state;
    logic [SR_W-1:0] sreg;
    logic [BC_W-1:0] byte_cnt;
    logic [31:0]     cyc_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            byte_cnt       <= '0;
            cyc_cnt        <= '0;
            o_tx_start     <= 1'b0;
            o_tx_data      <= 8'h00;
            o_busy         <= 1'b0;
            o_done_tick    <= 1'b0;
            o_timeout_tick <= 1'b0;
        end else begin
            o_tx_start     <= 1'b0;
            o_done_tick    <= 1'b0;
            o_timeout_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        sreg       <= {i_out_pattern, i_freq_pattern, i_ctrl};
                        byte_cnt   <= '0;
                        cyc_cnt    <= '0;
                        o_tx_data  <= i_out_pattern[DATA_BIT-1 -: 8];
                        o_tx_start <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: state <= WAIT;
                WAIT: begin
                    if (i_tx_done_tick) begin
                        if (byte_cnt == LAST_BYTE) begin
                            o_done_tick <= 1'b1;
                            state       <= DONE;
                        end else begin
                            sreg     <= sreg << 8;
                            byte_cnt <= byte_cnt + BC_W'(1);
                            cyc_cnt  <= '0;
                            if (GAP_CYCLES == 0) begin
                                // Next byte is the one just below the top of the unshifted register.
                                o_tx_data  <= sreg[SR_W-9 -: 8];
                                o_tx_start <= 1'b1;
                                state      <= SEND;
                            end else begin
                                state <= GAP;
                            end
                        end
                    // The SEND cycle counts toward the budget, so the tick lands
                    // TIMEOUT cycles after the start pulse.
                    end else if (TIMEOUT != 0 && (cyc_cnt + 32'd2) >= TO_LIM) begin
                        o_timeout_tick <= 1'b1;
                        state          <= ABORT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 32'd1;
                    end
                end
                GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        cyc_cnt    <= '0;
                        o_tx_data  <= sreg[SR_W-1 -: 8];
                        o_tx_start <= 1'b1;
                        state      <= SEND;
                    end else begin
                        cyc_cnt <= cyc_cnt + 32'd1;
                    end
                end
                DONE, ABORT: begin
                    o_busy    <= 1'b0;
                    o_tx_data <= 8'h00;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pack_tx.sv
// Randomized bench for uart_pack_tx: two instances (no gap / 4-cycle gap), a
// responding UART model and a byte/timing reference computed from the pack rules.
module tb_uart_pack_tx;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      start;
    logic [1:0]      done_in;
    logic [31:0]     out_pat;
    logic [31:0]     freq_pat;
    logic [7:0]      ctrl;
    logic [1:0]      tx_start;
    logic [1:0][7:0] tx_data;
    logic [1:0]      busy;
    logic [1:0]      done_tk;
    logic [1:0]      to_tk;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_pack_tx #(.DATA_BIT(32), .GAP_CYCLES(0), .TIMEOUT(50)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start[0]),
        .i_out_pattern(out_pat), .i_freq_pattern(freq_pat), .i_ctrl(ctrl),
        .o_tx_start(tx_start[0]), .o_tx_data(tx_data[0]), .i_tx_done_tick(done_in[0]),
        .o_busy(busy[0]), .o_done_tick(done_tk[0]), .o_timeout_tick(to_tk[0])
    );

    uart_pack_tx #(.DATA_BIT(32), .GAP_CYCLES(4), .TIMEOUT(50)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start[1]),
        .i_out_pattern(out_pat), .i_freq_pattern(freq_pat), .i_ctrl(ctrl),
        .o_tx_start(tx_start[1]), .o_tx_data(tx_data[1]), .i_tx_done_tick(done_in[1]),
        .o_busy(busy[1]), .o_done_tick(done_tk[1]), .o_timeout_tick(to_tk[1])
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 normal, 1 withhold byte-2 done (timeout), 2 reset in byte-5 WAIT,
    // 3 second start during byte 3.
    task automatic run_pack(input int i, input logic [31:0] out_v, input logic [31:0] freq_v,
                            input logic [7:0] ctrl_v, input int gap, input int mode);
        logic [7:0] exp_b[9];
        int k = 0, dn_cycle = -1, last_done = -1, done_ticks = 0, to_ticks = 0;
        int to_exp = -1, to_seen = -1, inject_cycle = -1, rst_cycle = -1, post_rst = -1;
        int stray = 0;
        bit finished = 0;
        for (int b = 0; b < 4; b++) begin
            exp_b[b]     = 8'((out_v >> (24 - 8 * b)) & 32'hFF);
            exp_b[b + 4] = 8'((freq_v >> (24 - 8 * b)) & 32'hFF);
        end
        exp_b[8] = ctrl_v;
        out_pat  = out_v;
        freq_pat = freq_v;
        ctrl     = ctrl_v;
        start[i] = 1'b1;
        next_cycle();
        start[i] = 1'b0;
        for (int c = 1; c <= 400 && !finished; c++) begin
            done_in[i] = 1'b0;
            if (post_rst >= 0) begin
                if (tx_start[i] || done_tk[i] || to_tk[i] || busy[i]) stray++;
                post_rst++;
                if (post_rst == 10) begin
                    check_val("no_activity_after_rst", 64'(stray), 64'd0);
                    finished = 1;
                end
            end else if (c == rst_cycle + 1) begin
                check_val("outputs_zero_on_rst",
                          {tx_start[i], tx_data[i], busy[i], done_tk[i], to_tk[i]}, 64'd0);
                rst      = 1'b0;
                post_rst = 0;
            end else begin
                if (tx_start[i]) begin
                    if (k < 9) check_val($sformatf("byte%0d", k), tx_data[i], exp_b[k]);
                    if (k == 0) check_val("first_pulse_cycle", 64'(c), 64'd1);
                    else        check_val("done_to_pulse", 64'(c - last_done), 64'(1 + gap));
                    if (mode == 1 && k == 2) to_exp = c + 50;
                    else                     dn_cycle = c + 5;
                    if (mode == 3 && k == 3) inject_cycle = c + 2;
                    if (mode == 2 && k == 5) rst_cycle = c + 3;
                    k++;
                end
                if (mode == 3) begin
                    start[i] = (c == inject_cycle);
                    if (c == inject_cycle) out_pat = 32'hFFFF_FFFF;
                end
                if (c == rst_cycle) begin
                    rst      = 1'b1;
                    dn_cycle = -1;
                end
                if (c == dn_cycle) begin
                    done_in[i] = 1'b1;
                    last_done  = c;
                end
                if (done_tk[i]) begin
                    done_ticks++;
                    check_val("done_tick_cycle", 64'(c), 64'(last_done + 1));
                end
                if (to_tk[i]) begin
                    to_ticks++;
                    to_seen = c;
                    check_val("timeout_cycle", 64'(c), 64'(to_exp));
                end
                if (!busy[i] && rst_cycle < 0) begin
                    if (mode == 1) begin
                        check_val("busy_low_after_timeout", 64'(c), 64'(to_seen + 1));
                        check_val("timeout_ticks", 64'(to_ticks), 64'd1);
                        check_val("no_done_on_abort", 64'(done_ticks), 64'd0);
                        check_val("bytes_before_abort", 64'(k), 64'd3);
                    end else begin
                        check_val("busy_low_cycle", 64'(c), 64'(last_done + 2));
                        check_val("done_ticks", 64'(done_ticks), 64'd1);
                        check_val("no_timeout", 64'(to_ticks), 64'd0);
                        check_val("bytes_sent", 64'(k), 64'd9);
                    end
                    finished = 1;
                end
            end
            if (!finished) next_cycle();
        end
        start[i]   = 1'b0;
        done_in[i] = 1'b0;
        rst        = 1'b0;
        if (!finished) check_val("pack_ended_in_budget", 64'd0, 64'd1);
    endtask

    task automatic back_to_back(input int i);
        int last_pulse = -100, lowrun = 0, prev_first = -1, packs = 0;
        bit prev_busy = 0, ended = 0;
        out_pat  = $urandom;
        freq_pat = $urandom;
        ctrl     = 8'($urandom);
        start[i] = 1'b1;
        for (int c = 0; c < 300 && packs < 4; c++) begin
            next_cycle();
            done_in[i] = (c == last_pulse + 1);
            if (tx_start[i]) last_pulse = c;
            if (busy[i] && !prev_busy) begin
                check_val("b2b_pulse_on_start", 64'(tx_start[i]), 64'd1);
                if (prev_first >= 0) begin
                    check_val("b2b_idle_len", 64'(lowrun), 64'd1);
                    check_val("b2b_pack_period", 64'(c - prev_first), 64'd20);
                end
                prev_first = c;
                packs++;
                lowrun = 0;
            end
            if (!busy[i]) lowrun++;
            prev_busy = busy[i];
        end
        start[i] = 1'b0;
        check_val("b2b_packs", 64'(packs), 64'd4);
        for (int c = 0; c < 100 && !ended; c++) begin
            next_cycle();
            done_in[i] = tx_start[i] ? 1'b0 : (last_pulse >= 0 && done_in[i] == 1'b0 && c == last_pulse + 1);
            if (tx_start[i]) last_pulse = c;
            if (!busy[i]) ended = 1;
        end
        done_in[i] = 1'b0;
        check_val("b2b_drained", 64'(ended), 64'd1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = '0;
        done_in  = '0;
        out_pat  = '0;
        freq_pat = '0;
        ctrl     = '0;
        repeat (3) next_cycle();
        for (int i = 0; i < 2; i++) begin
            check_val("rst_tx_start", 64'(tx_start[i]), 64'd0);
            check_val("rst_tx_data", 64'(tx_data[i]), 64'd0);
            check_val("rst_busy", 64'(busy[i]), 64'd0);
            check_val("rst_ticks", 64'({done_tk[i], to_tk[i]}), 64'd0);
        end
        rst = 1'b0;
        next_cycle();

        run_pack(0, 32'h1234_5678, 32'h9ABC_DEF0, 8'hA5, 0, 0);
        run_pack(0, $urandom, $urandom, 8'($urandom), 0, 3);
        run_pack(1, $urandom, $urandom, 8'($urandom), 4, 0);
        run_pack(0, $urandom, $urandom, 8'($urandom), 0, 1);
        run_pack(0, $urandom, $urandom, 8'($urandom), 0, 0);
        run_pack(0, $urandom, $urandom, 8'($urandom), 0, 2);
        run_pack(0, $urandom, $urandom, 8'($urandom), 0, 0);
        back_to_back(0);
        for (int r = 0; r < 4; r++) begin
            int inst;
            inst = int'($urandom_range(0, 1));
            run_pack(inst, $urandom, $urandom, 8'($urandom), inst * 4, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
